// File: rtl/bsg_mem_1r1w_drain_if.sv
// Bundle of the command, memory read port and output stream signals for
// bsg_mem_1r1w_drain.
//   master : the drain engine (drives cmd_ready_o, mem_r_*, data_*, done_o)
//   slave  : the surrounding system (drives cmd_*, mem_r_data_i, yumi_i)
interface bsg_mem_1r1w_drain_if #(
    parameter int width_p     = 8,
    parameter int els_p       = 16,
    parameter int len_width_p = 8
);
    localparam int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p);

    logic                     cmd_v_i;
    logic [addr_width_lp-1:0] cmd_addr_i;
    logic [len_width_p-1:0]   cmd_len_i;
    logic                     cmd_ready_o;

    logic                     mem_r_v_o;
    logic [addr_width_lp-1:0] mem_r_addr_o;
    logic [width_p-1:0]       mem_r_data_i;

    logic                     data_v_o;
    logic [width_p-1:0]       data_o;
    logic                     data_last_o;
    logic                     yumi_i;

    logic                     done_o;

    modport master (
        input  cmd_v_i, cmd_addr_i, cmd_len_i, mem_r_data_i, yumi_i,
        output cmd_ready_o, mem_r_v_o, mem_r_addr_o, data_v_o, data_o,
               data_last_o, done_o
    );

    modport slave (
        output cmd_v_i, cmd_addr_i, cmd_len_i, mem_r_data_i, yumi_i,
        input  cmd_ready_o, mem_r_v_o, mem_r_addr_o, data_v_o, data_o,
               data_last_o, done_o
    );
endinterface

// File: rtl/bsg_mem_1r1w_drain.sv
// Read-side engine for a bsg_mem_1r1w. Takes (start address, word count),
// walks the memory's asynchronous read port and streams the words out on a
// valid/yumi interface through a 2-entry buffer, flagging the final word.
//
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   io (master)    : cmd_v_i/cmd_addr_i/cmd_len_i/cmd_ready_o command,
//                    mem_r_v_o/mem_r_addr_o/mem_r_data_i memory read port,
//                    data_v_o/data_o/data_last_o/yumi_i output stream,
//                    done_o one-cycle completion pulse
//   stall_cnt_o    : only with BSG_MEM_1R1W_DRAIN_STALL_CNT_EN defined;
//                    saturating count of cycles with data_v_o & ~yumi_i,
//                    cleared on command accept
//
// width_p / els_p must be set to match the attached memory and the io
// interface instance.
module bsg_mem_1r1w_drain #(
    parameter int width_p     = 8,
    parameter int els_p       = 16,
    parameter int len_width_p = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    bsg_mem_1r1w_drain_if.master      io
`ifdef BSG_MEM_1R1W_DRAIN_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);
    localparam int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p);
    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
    localparam logic [len_width_p-1:0]   len_one_lp   = len_width_p'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]               state;
    logic [addr_width_lp-1:0] addr;
    logic [len_width_p-1:0]   rem;

    logic [1:0][width_p-1:0]  buf_data;
    logic [1:0]               buf_last;
    logic                     rd_ptr, wr_ptr;
    logic [1:0]               buf_count;

    logic accept, issue, pop;

    assign io.cmd_ready_o  = (state == IDLE) & ~reset_i;
    assign accept          = io.cmd_v_i & io.cmd_ready_o;
    // Registered count gates the read, so a push never lands on a full buffer.
    assign issue           = (state == READ) & (buf_count != 2'd2);
    assign pop             = io.yumi_i & io.data_v_o;

    assign io.mem_r_v_o    = issue;
    assign io.mem_r_addr_o = addr;
    assign io.data_v_o     = (buf_count != 2'd0);
    assign io.data_o       = buf_data[rd_ptr];
    assign io.data_last_o  = io.data_v_o & buf_last[rd_ptr];
    assign io.done_o       = (state == DONE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            addr  <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    addr  <= io.cmd_addr_i;
                    rem   <= io.cmd_len_i;
                    state <= (io.cmd_len_i != '0) ? READ : DONE;
                end
                READ: if (issue) begin
                    rem  <= rem - len_one_lp;
                    addr <= (addr == last_addr_lp) ? '0 : addr + 1'b1;
                    if (rem == len_one_lp) state <= DRAIN;
                end
                // No pushes here, so count 1 with a pop means the last word left.
                DRAIN: if (pop && buf_count == 2'd1) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buf_data  <= '0;
            buf_last  <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (issue) begin
                buf_data[wr_ptr] <= io.mem_r_data_i;
                buf_last[wr_ptr] <= (rem == len_one_lp);
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            buf_count <= buf_count + {1'b0, issue} - {1'b0, pop};
        end
    end

`ifdef BSG_MEM_1R1W_DRAIN_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            stall_cnt <= '0;
        else if (accept)
            stall_cnt <= '0;
        else if (io.data_v_o && !io.yumi_i && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cnt_o = stall_cnt;
`endif

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i) begin
            if (accept) begin
                assert (32'(io.cmd_addr_i) < els_p)
                    else $error("cmd_addr_i out of range");
                assert (32'(io.cmd_len_i) <= els_p)
                    else $error("cmd_len_i exceeds memory depth");
            end
            assert (!io.yumi_i || io.data_v_o)
                else $error("yumi_i without data_v_o");
        end
    end
`endif
endmodule
